// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the data memory controller: access sizes,
// FSM state constants and the access legality check.
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // An access is illegal when the address is not a multiple of the size,
    // or when a dword is requested from a 32-bit wide memory.
    function automatic logic access_error(input logic [1:0] size,
                                          input logic [2:0] addr_lo,
                                          input int         data_width);
        logic bad_align;
        case (size)
            SZ_HALF:  bad_align = addr_lo[0];
            SZ_WORD:  bad_align = |addr_lo[1:0];
            SZ_DWORD: bad_align = |addr_lo;
            default:  bad_align = 1'b0;
        endcase
        return bad_align || (size == SZ_DWORD && data_width == 32);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Big-endian lane steering: byte offset 0 is the most-significant byte of a
// line. Produces the store merge mask/data and the extended load value.
module mem_byte_lane
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                        size,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset,
    input  logic                              sign_ext,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [DATA_WIDTH-1:0]             line,
    output logic [DATA_WIDTH-1:0]             lane_mask,
    output logic [DATA_WIDTH-1:0]             wdata_shifted,
    output logic [DATA_WIDTH-1:0]             rdata
);

    int                    nbits;
    int                    shamt;
    logic [DATA_WIDTH-1:0] field_mask;
    logic [DATA_WIDTH-1:0] raw;
    logic                  sign_bit;

    always_comb begin
        nbits = 8 << size;
        // The last addressed byte sits shamt bits above bit 0 of the line.
        shamt = DATA_WIDTH - 8 * (int'(offset) + (1 << size));
        if (shamt < 0) begin
            shamt = 0;
        end
        field_mask    = ~({DATA_WIDTH{1'b1}} << nbits);
        lane_mask     = field_mask << shamt;
        wdata_shifted = (wdata & field_mask) << shamt;
        raw           = (line >> shamt) & field_mask;
        sign_bit      = |(raw & field_mask & ~(field_mask >> 1));
        if (sign_ext && sign_bit) begin
            rdata = raw | ~field_mask;
        end else begin
            rdata = raw;
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory behind a valid/ready request/response port with big-endian
// sub-line access, configurable wait states and misalignment reporting.
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 20,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid &&
    // req_ready; a response transfers on an edge where resp_valid && resp_ready.
    localparam int LB = $clog2(DATA_WIDTH / 8);
    localparam int IW = DEPTH_LOG2 + LB;
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t                state;
    logic [CW-1:0]         wait_cnt;

    logic                  h_write;
    logic                  h_signed;
    logic [1:0]            h_size;
    logic [IW-1:0]         h_addr;
    logic [DATA_WIDTH-1:0] h_wdata;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0] line_idx;
    logic [DATA_WIDTH-1:0] line;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] wdata_shifted;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  acc_err;
    logic                  commit;
    logic                  unused_addr_hi;

    // Address bits above the line index alias onto the same line.
    assign unused_addr_hi = &{1'b0, req_addr[ADDR_WIDTH-1:IW]};

    assign line_idx   = h_addr[IW-1:LB];
    assign line       = mem[line_idx];
    assign acc_err    = access_error(h_size, h_addr[2:0], DATA_WIDTH);
    assign commit     = (state == ST_ACCESS) && h_write && !acc_err && !rst;
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign dbg_state  = state;

    mem_byte_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .size          (h_size),
        .offset        (h_addr[LB-1:0]),
        .sign_ext      (h_signed),
        .wdata         (h_wdata),
        .line          (line),
        .lane_mask     (lane_mask),
        .wdata_shifted (wdata_shifted),
        .rdata         (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (req_valid) begin
                        state <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == CW'(WAIT_STATES - 1)) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_ACCESS: begin
                    state      <= ST_RESP;
                    resp_err   <= acc_err;
                    resp_rdata <= (acc_err || h_write) ? '0 : load_data;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            h_write  <= req_write;
            h_signed <= req_signed;
            h_size   <= req_size;
            h_addr   <= req_addr[IW-1:0];
            h_wdata  <= req_wdata;
        end
    end

    // Array contents survive reset; only the ACCESS->RESP edge writes.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[line_idx] <= (line & ~lane_mask) | (wdata_shifted & lane_mask);
        end
    end

endmodule
